// File: rtl/uart_pkg.sv
// uart_pkg: types and defaults shared by the UART blocks (uart_top and uart_tx_buffer).
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock byte FIFO with level counter and overflow pulse.
// Ports: clk/rst (async active-low), wr_en/wr_data write side, rd_en/rd_data
// show-ahead read side, full/empty/level status, overflow = dropped write last cycle.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              overflow
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q, level_d;
    logic              overflow_q;
    logic              wr_acc, rd_acc;

    // Full/empty derive from the registered level, so a pop frees space only from the next cycle on.
    assign full    = level_q == (AW+1)'(DEPTH);
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign overflow = overflow_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign level_d = level_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q   <= rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
            level_q    <= level_d;
            overflow_q <= wr_en && full;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO plus launch sequencer feeding uart_top one byte at a time.
// Ports: clk/rst (async active-low); wr_en/wr_data producer side; full/empty/level/overflow
// FIFO status; tx_start/tx_data to uart_top, busy from uart_top; ack_err sticky handshake
// timeout flag, cleared by err_clr (clear wins over a same-cycle set).
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 15,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              busy,
    output logic              ack_err,
    input  logic              err_clr
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    // WAIT_BUSY lasts at most ACK_TIMEOUT cycles, so ack_err appears ACK_TIMEOUT+1 cycles after tx_start.
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    tx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, ack_err_q, ack_err_d;
    logic              pop, err_set;
    logic [DATA_W-1:0] rd_data;

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (rd_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            IDLE: if (!empty && !busy) begin
                pop       = 1'b1;
                tx_data_d = rd_data;
                state_d   = LAUNCH;
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (busy) state_d = WAIT_DONE;
                else if (cnt_q == CNT_LAST) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else cnt_d = cnt_q + 1'b1;
            WAIT_DONE: if (!busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ack_err_d = err_clr ? 1'b0 : (ack_err_q || err_set);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= state_d == LAUNCH;
            ack_err_q  <= ack_err_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign ack_err  = ack_err_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed bench with a busy-handshake responder and a byte scoreboard.
module tb_uart_tx_buffer;
    localparam int DEPTH    = 16;
    localparam int AT       = 15;
    localparam int BUSY_CYC = 10;

    logic       clk = 1'b0, rst = 1'b0, wr_en = 1'b0, err_clr = 1'b0;
    logic       ext_busy = 1'b0, model_en = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       busy, full, empty, overflow, tx_start, ack_err;
    logic [4:0] level;
    logic [7:0] tx_data;

    int         vectors = 0, miscompares = 0, n_start = 0;
    int         mcnt = 0;
    logic       busy_pre = 1'b0, start_prev = 1'b0;
    logic [7:0] sb[$];

    assign busy = ext_busy | (mcnt != 0);

    always #10 clk = ~clk;

    uart_tx_buffer #(.DATA_W(8), .DEPTH(DEPTH), .ACK_TIMEOUT(AT)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .ack_err  (ack_err),
        .err_clr  (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter stand-in: busy rises the cycle after tx_start and holds BUSY_CYC cycles; not reset by rst.
    always @(posedge clk) begin
        busy_pre <= busy;
        if (model_en && tx_start) mcnt <= BUSY_CYC;
        else if (mcnt != 0) mcnt <= mcnt - 1;
    end

    always @(negedge clk) begin
        if (rst && tx_start) begin
            n_start++;
            chk("start_while_busy_low", busy_pre, 0);
            chk("start_not_back_to_back", start_prev, 0);
            if (sb.size() == 0) chk("start_unexpected", 1, 0);
            else chk("tx_data_order", tx_data, sb.pop_front());
        end
        start_prev <= rst && tx_start;
    end

    task automatic drain(input string tag);
        int k = 0;
        while ((sb.size() != 0 || !empty || busy || tx_start) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, k < 3000, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] burst [4];
        int k;
        burst = '{8'hAA, 8'hCC, 8'h0F, 8'hF0};
        #50;
        @(negedge clk) rst = 1'b1;
        // Reset state
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_ack_err", ack_err, 0);
        // 1: single byte, start latency
        @(negedge clk) begin wr_en = 1'b1; wr_data = 8'hAA; sb.push_back(8'hAA); end
        @(negedge clk) wr_en = 1'b0;
        chk("t1_no_early_start", tx_start, 0);
        chk("t1_level", level, 1);
        @(negedge clk);
        chk("t1_start_latency", tx_start, 1);
        chk("t1_tx_data", tx_data, 8'hAA);
        drain("t1_drain");
        chk("t1_start_count", n_start, 1);
        // 2: burst of four held back by busy, then drained in order
        ext_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) begin wr_en = 1'b1; wr_data = burst[i]; sb.push_back(burst[i]); end
        end
        @(negedge clk) wr_en = 1'b0;
        chk("t2_level", level, 4);
        ext_busy = 1'b0;
        drain("t2_drain");
        chk("t2_start_count", n_start, 5);
        // 3: fill to full while busy held, 17th byte overflows
        ext_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk("t3_level", level, i);
            chk("t3_no_overflow", overflow, 0);
            chk("t3_full", full, i == 16);
            wr_en = 1'b1;
            wr_data = 8'(i);
            if (i < 16) sb.push_back(8'(i));
        end
        @(negedge clk) wr_en = 1'b0;
        chk("t3_overflow_pulse", overflow, 1);
        chk("t3_level_full", level, 16);
        chk("t3_full_held", full, 1);
        @(negedge clk);
        chk("t3_overflow_single", overflow, 0);
        // 4: write on the pop cycle is still dropped
        ext_busy = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'hEE;
        @(negedge clk) wr_en = 1'b0;
        chk("t4_overflow", overflow, 1);
        chk("t4_full_clear", full, 0);
        chk("t4_level", level, 15);
        chk("t4_tx_start", tx_start, 1);
        drain("t4_drain");
        chk("t4_start_count", n_start, 21);
        // 5: no busy response -> ack_err after ACK_TIMEOUT+1 cycles
        model_en = 1'b0;
        @(negedge clk) begin wr_en = 1'b1; wr_data = 8'h55; sb.push_back(8'h55); end
        @(negedge clk) wr_en = 1'b0;
        @(negedge clk);
        chk("t5_tx_start", tx_start, 1);
        k = 0;
        while (!ack_err && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t5_ack_err_delay", k, AT + 1);
        repeat (5) @(negedge clk);
        chk("t5_ack_err_sticky", ack_err, 1);
        chk("t5_no_retry", n_start, 22);
        err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        chk("t5_err_clr", ack_err, 0);
        model_en = 1'b1;
        @(negedge clk) begin wr_en = 1'b1; wr_data = 8'h3C; sb.push_back(8'h3C); end
        @(negedge clk) wr_en = 1'b0;
        drain("t5_drain_after_err");
        chk("t5_start_count", n_start, 23);
        // 6: reset during WAIT_DONE discards queued bytes
        @(negedge clk) begin wr_en = 1'b1; wr_data = 8'h11; sb.push_back(8'h11); end
        @(negedge clk) wr_data = 8'h22;
        @(negedge clk) wr_data = 8'h33;
        @(negedge clk) wr_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_busy_before_rst", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_tx_start", tx_start, 0);
        chk("t6_rst_tx_data", tx_data, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_full", full, 0);
        chk("t6_rst_overflow", overflow, 0);
        chk("t6_rst_ack_err", ack_err, 0);
        @(negedge clk) rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_no_start_after_rst", n_start, 24);
        chk("t6_level_after_rst", level, 0);
        chk("t6_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
